// File: rtl/move_validator_board_if.sv
// Request/status bundle between the input decoder and the board store.
// One-hot per-player move requests go in; board contents and game status come out.
interface move_validator_board_if #(
    parameter int unsigned CELLS = 9
);
    localparam int unsigned CNT_W = $clog2(CELLS + 1);

    logic                 clear;
    logic [CELLS-1:0]     PL1_en;
    logic [CELLS-1:0]     PL2_en;
    logic [2*CELLS-1:0]   board;
    logic                 turn;
    logic                 move_ok;
    logic                 illegal_move;
    logic                 illegal_led;
    logic                 board_full;
    logic [CNT_W-1:0]     move_count;

    modport master (
        output clear, PL1_en, PL2_en,
        input  board, turn, move_ok, illegal_move, illegal_led, board_full, move_count
    );

    modport slave (
        input  clear, PL1_en, PL2_en,
        output board, turn, move_ok, illegal_move, illegal_led, board_full, move_count
    );
endinterface

// File: rtl/move_validator_board.sv
// Registered board store and move validator: enforces turn order, commits legal moves,
// rejects illegal ones and stretches the rejection into a visible LED indication.
module move_validator_board #(
    parameter int unsigned CELLS        = 9,
    parameter int unsigned ILLEGAL_HOLD = 50000000,
    parameter bit          FIRST_PLAYER = 1'b0
) (
    input logic                   clk,
    input logic                   reset,
    move_validator_board_if.slave bus
);
    localparam int unsigned CNT_W  = $clog2(CELLS + 1);
    localparam int unsigned HOLD_W = (ILLEGAL_HOLD > 0) ? $clog2(ILLEGAL_HOLD + 1) : 1;
    localparam int unsigned REQ_W  = 2 * CELLS;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ILLEGAL_HOLD);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CELLS - 1);
    localparam logic [REQ_W-1:0]  REQ_ONE   = {{(REQ_W - 1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StPlay, StFull} state_e;

    state_e            state_q, state_d;
    logic [REQ_W-1:0]  board_q, board_d;
    logic              turn_q, turn_d;
    logic              move_ok_q, move_ok_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [REQ_W-1:0]  req;
    logic [CELLS-1:0]  occupied;
    logic [CELLS-1:0]  mine;
    logic [CELLS-1:0]  other;
    logic              one_hot;
    logic              legal;

    always_comb begin
        req      = {bus.PL2_en, bus.PL1_en};
        occupied = '0;
        for (int i = 0; i < CELLS; i++) begin
            occupied[i] = |board_q[2*i +: 2];
        end
        mine    = turn_q ? bus.PL2_en : bus.PL1_en;
        other   = turn_q ? bus.PL1_en : bus.PL2_en;
        // Exactly one bit across both players' requests combined.
        one_hot = (req != '0) && ((req & (req - REQ_ONE)) == '0);
        legal   = one_hot && (other == '0) && ((mine & occupied) == '0) && (state_q == StPlay);
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        turn_d    = turn_q;
        count_d   = count_q;
        move_ok_d = 1'b0;
        illegal_d = 1'b0;
        hold_d    = (hold_q != '0) ? hold_q - 1'b1 : hold_q;

        if (bus.clear) begin
            // New game: the LED stretch keeps running so a late rejection stays visible.
            state_d = StPlay;
            board_d = '0;
            turn_d  = FIRST_PLAYER;
            count_d = '0;
        end else if (req != '0) begin
            if (legal) begin
                for (int i = 0; i < CELLS; i++) begin
                    if (mine[i]) begin
                        board_d[2*i +: 2] = turn_q ? 2'b10 : 2'b01;
                    end
                end
                turn_d    = ~turn_q;
                count_d   = count_q + 1'b1;
                move_ok_d = 1'b1;
                unique case (state_q)
                    StPlay:  state_d = (count_q == LAST_CNT) ? StFull : StPlay;
                    StFull:  state_d = StFull;
                    default: state_d = StPlay;
                endcase
            end else begin
                illegal_d = 1'b1;
                hold_d    = HOLD_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StPlay;
            board_q   <= '0;
            turn_q    <= FIRST_PLAYER;
            count_q   <= '0;
            move_ok_q <= 1'b0;
            illegal_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            turn_q    <= turn_d;
            count_q   <= count_d;
            move_ok_q <= move_ok_d;
            illegal_q <= illegal_d;
            hold_q    <= hold_d;
        end
    end

    assign bus.board        = board_q;
    assign bus.turn         = turn_q;
    assign bus.move_ok      = move_ok_q;
    assign bus.illegal_move = illegal_q;
    assign bus.illegal_led  = (ILLEGAL_HOLD == 0) ? illegal_q : (hold_q != '0);
    assign bus.board_full   = (state_q == StFull);
    assign bus.move_count   = count_q;
endmodule

// File: tb/tb_move_validator_board.sv
// Bench for move_validator_board: table vectors, hand sequences and randomized traffic
// on three configurations, all checked against a rule-level reference model.
module tb_move_validator_board;
    logic clk = 1'b0;
    logic rst9, rst16, rst2;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    move_validator_board_if #(.CELLS(9))  if9  ();
    move_validator_board_if #(.CELLS(16)) if16 ();
    move_validator_board_if #(.CELLS(2))  if2  ();

    move_validator_board #(.CELLS(9), .ILLEGAL_HOLD(4), .FIRST_PLAYER(1'b0)) dut9 (
        .clk(clk), .reset(rst9), .bus(if9)
    );
    move_validator_board #(.CELLS(16), .ILLEGAL_HOLD(4), .FIRST_PLAYER(1'b1)) dut16 (
        .clk(clk), .reset(rst16), .bus(if16)
    );
    move_validator_board #(.CELLS(2), .ILLEGAL_HOLD(0), .FIRST_PLAYER(1'b0)) dut2 (
        .clk(clk), .reset(rst2), .bus(if2)
    );

    typedef struct packed {
        logic [127:0] board;
        logic         turn;
        int unsigned  count;
        logic         full;
        int unsigned  hold;
        logic         ok;
        logic         ill;
    } model_t;

    model_t m9, m16, m2;

    // Game rules applied to one clock edge.
    function automatic model_t step(model_t m, logic rst, logic clr, logic [63:0] p1,
                                    logic [63:0] p2, int unsigned cells, int unsigned hold,
                                    logic fp);
        model_t r;
        int     n;
        int     idx;
        logic   who;
        r     = m;
        r.ok  = 1'b0;
        r.ill = 1'b0;
        if (rst) begin
            r.board = '0; r.turn = fp; r.count = 0; r.full = 1'b0; r.hold = 0;
            return r;
        end
        if (r.hold != 0) r.hold = r.hold - 1;
        if (clr) begin
            r.board = '0; r.turn = fp; r.count = 0; r.full = 1'b0;
            return r;
        end
        if ((p1 | p2) == 64'd0) return r;
        n   = $countones(p1) + $countones(p2);
        idx = 0;
        for (int i = 0; i < 64; i++) if (p1[i] | p2[i]) idx = i;
        who = (p2 != 64'd0);
        if (n == 1 && !r.full && who == r.turn && r.board[2*idx +: 2] == 2'b00) begin
            r.board[2*idx +: 2] = who ? 2'b10 : 2'b01;
            r.turn  = ~r.turn;
            r.count = r.count + 1;
            r.full  = (r.count == cells);
            r.ok    = 1'b1;
        end else begin
            r.ill  = 1'b1;
            r.hold = hold;
        end
        return r;
    endfunction

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input model_t m, input logic [127:0] brd,
                             input logic trn, input logic ok, input logic ill, input logic led,
                             input logic full, input int cnt, input int unsigned hold);
        logic exp_led;
        exp_led = (hold == 0) ? m.ill : (m.hold != 0);
        cmp({tag, " board"}, brd, m.board);
        cmp({tag, " turn"}, 128'(trn), 128'(m.turn));
        cmp({tag, " move_ok"}, 128'(ok), 128'(m.ok));
        cmp({tag, " illegal_move"}, 128'(ill), 128'(m.ill));
        cmp({tag, " illegal_led"}, 128'(led), 128'(exp_led));
        cmp({tag, " board_full"}, 128'(full), 128'(m.full));
        cmp({tag, " move_count"}, 128'(cnt), 128'(m.count));
    endtask

    task automatic cyc9(input logic rst, input logic clr, input logic [8:0] p1,
                        input logic [8:0] p2);
        rst9 = rst; if9.clear = clr; if9.PL1_en = p1; if9.PL2_en = p2;
        @(posedge clk);
        m9 = step(m9, rst, clr, 64'(p1), 64'(p2), 9, 4, 1'b0);
        #1;
        rst9 = 1'b0; if9.clear = 1'b0; if9.PL1_en = '0; if9.PL2_en = '0;
        check_dut("d9", m9, 128'(if9.board), if9.turn, if9.move_ok, if9.illegal_move,
                  if9.illegal_led, if9.board_full, int'(if9.move_count), 4);
    endtask

    task automatic cyc16(input logic rst, input logic clr, input logic [15:0] p1,
                         input logic [15:0] p2);
        rst16 = rst; if16.clear = clr; if16.PL1_en = p1; if16.PL2_en = p2;
        @(posedge clk);
        m16 = step(m16, rst, clr, 64'(p1), 64'(p2), 16, 4, 1'b1);
        #1;
        rst16 = 1'b0; if16.clear = 1'b0; if16.PL1_en = '0; if16.PL2_en = '0;
        check_dut("d16", m16, 128'(if16.board), if16.turn, if16.move_ok, if16.illegal_move,
                  if16.illegal_led, if16.board_full, int'(if16.move_count), 4);
    endtask

    task automatic cyc2(input logic rst, input logic clr, input logic [1:0] p1,
                        input logic [1:0] p2);
        rst2 = rst; if2.clear = clr; if2.PL1_en = p1; if2.PL2_en = p2;
        @(posedge clk);
        m2 = step(m2, rst, clr, 64'(p1), 64'(p2), 2, 0, 1'b0);
        #1;
        rst2 = 1'b0; if2.clear = 1'b0; if2.PL1_en = '0; if2.PL2_en = '0;
        check_dut("d2", m2, 128'(if2.board), if2.turn, if2.move_ok, if2.illegal_move,
                  if2.illegal_led, if2.board_full, int'(if2.move_count), 0);
    endtask

    // Mostly single-cell requests from the player to move, with some rule breakers mixed in.
    task automatic gen(input int unsigned cells, input logic turn, output logic [63:0] p1,
                       output logic [63:0] p2);
        int unsigned r;
        logic [63:0] b;
        logic        pl;
        p1 = '0;
        p2 = '0;
        r  = $urandom_range(99);
        if (r < 15) return;
        b  = 64'd1 << $urandom_range(cells - 1);
        pl = ($urandom_range(3) != 0) ? turn : ~turn;
        if (pl) p2 = b; else p1 = b;
        if (r < 22) p1 = p1 | (64'd1 << $urandom_range(cells - 1));
        else if (r < 28) p2 = p2 | (64'd1 << $urandom_range(cells - 1));
    endtask

    typedef struct {
        logic [8:0]  p1;
        logic [8:0]  p2;
        logic        clr;
        logic        ok;
        logic        ill;
        logic        turn;
        logic [17:0] brd;
        int          cnt;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [63:0] r1, r2;
        logic        rr, rc;

        tbl[0] = '{9'h001, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 18'h00001, 1};
        tbl[1] = '{9'h002, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1, 18'h00001, 1};
        tbl[2] = '{9'h000, 9'h001, 1'b0, 1'b0, 1'b1, 1'b1, 18'h00001, 1};
        tbl[3] = '{9'h000, 9'h003, 1'b0, 1'b0, 1'b1, 1'b1, 18'h00001, 1};
        tbl[4] = '{9'h010, 9'h010, 1'b0, 1'b0, 1'b1, 1'b1, 18'h00001, 1};
        tbl[5] = '{9'h000, 9'h002, 1'b0, 1'b1, 1'b0, 1'b0, 18'h00009, 2};
        tbl[6] = '{9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00009, 2};
        tbl[7] = '{9'h004, 9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 18'h00019, 3};
        tbl[8] = '{9'h000, 9'h008, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00000, 0};

        rst9 = 1'b0; rst16 = 1'b0; rst2 = 1'b0;
        if9.clear = 1'b0;  if9.PL1_en = '0;  if9.PL2_en = '0;
        if16.clear = 1'b0; if16.PL1_en = '0; if16.PL2_en = '0;
        if2.clear = 1'b0;  if2.PL1_en = '0;  if2.PL2_en = '0;
        m9 = '0; m16 = '0; m2 = '0;

        // 3x3 board: reset state, then the table.
        cyc9(1'b1, 1'b0, '0, '0);
        cmp("reset board", 128'(if9.board), 128'd0);
        cmp("reset turn", 128'(if9.turn), 128'd0);
        cmp("reset led", 128'(if9.illegal_led), 128'd0);
        for (int i = 0; i < 9; i++) begin
            cyc9(1'b0, tbl[i].clr, tbl[i].p1, tbl[i].p2);
            cmp($sformatf("tbl%0d ok", i), 128'(if9.move_ok), 128'(tbl[i].ok));
            cmp($sformatf("tbl%0d ill", i), 128'(if9.illegal_move), 128'(tbl[i].ill));
            cmp($sformatf("tbl%0d turn", i), 128'(if9.turn), 128'(tbl[i].turn));
            cmp($sformatf("tbl%0d board", i), 128'(if9.board), 128'(tbl[i].brd));
            cmp($sformatf("tbl%0d count", i), 128'(if9.move_count), 128'(tbl[i].cnt));
        end

        // Fill all nine cells alternately, then probe the full board and the LED stretch.
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 0) cyc9(1'b0, 1'b0, 9'd1 << i, '0);
            else            cyc9(1'b0, 1'b0, '0, 9'd1 << i);
        end
        cmp("fill count", 128'(if9.move_count), 128'd9);
        cmp("fill full", 128'(if9.board_full), 128'd1);
        cmp("fill board", 128'(if9.board), 128'h19999);
        cyc9(1'b0, 1'b0, '0, 9'h001);
        cmp("full req ill", 128'(if9.illegal_move), 128'd1);
        cmp("full req led", 128'(if9.illegal_led), 128'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc9(1'b0, 1'b0, '0, '0);
            cmp($sformatf("hold led %0d", k), 128'(if9.illegal_led), 128'(k < 4));
        end
        cyc9(1'b0, 1'b1, '0, 9'h001);
        cmp("clr full", 128'(if9.board_full), 128'd0);
        cmp("clr count", 128'(if9.move_count), 128'd0);
        cmp("clr ok", 128'(if9.move_ok), 128'd0);

        for (int n = 0; n < 400; n++) begin
            gen(9, m9.turn, r1, r2);
            rc = ($urandom_range(39) == 0);
            rr = ($urandom_range(149) == 0);
            cyc9(rr, rc, r1[8:0], r2[8:0]);
        end

        // 4x4 board, player 2 first.
        cyc16(1'b1, 1'b0, '0, '0);
        cmp("d16 reset turn", 128'(if16.turn), 128'd1);
        cyc16(1'b0, 1'b0, '0, 16'h8000);
        cmp("d16 cell15", 128'(if16.board[31:30]), 128'd2);
        cmp("d16 turn", 128'(if16.turn), 128'd0);
        cyc16(1'b0, 1'b0, '0, 16'h0001);
        cmp("d16 wrong ill", 128'(if16.illegal_move), 128'd1);
        cyc16(1'b0, 1'b0, '0, '0);
        cmp("d16 hold led", 128'(if16.illegal_led), 128'd1);
        cyc16(1'b1, 1'b0, '0, '0);
        cmp("d16 reset led", 128'(if16.illegal_led), 128'd0);
        for (int n = 0; n < 400; n++) begin
            gen(16, m16.turn, r1, r2);
            rc = ($urandom_range(59) == 0);
            rr = ($urandom_range(199) == 0);
            cyc16(rr, rc, r1[15:0], r2[15:0]);
        end

        // Two-cell board without LED stretch.
        cyc2(1'b1, 1'b0, '0, '0);
        cyc2(1'b0, 1'b0, '0, 2'b01);
        cmp("d2 ill led", 128'(if2.illegal_led), 128'd1);
        cyc2(1'b0, 1'b0, '0, '0);
        cmp("d2 led off", 128'(if2.illegal_led), 128'd0);
        cyc2(1'b0, 1'b0, 2'b01, '0);
        cyc2(1'b0, 1'b0, '0, 2'b10);
        cmp("d2 full", 128'(if2.board_full), 128'd1);
        cmp("d2 board", 128'(if2.board), 128'h9);
        for (int n = 0; n < 300; n++) begin
            gen(2, m2.turn, r1, r2);
            rc = ($urandom_range(9) == 0);
            rr = ($urandom_range(99) == 0);
            cyc2(rr, rc, r1[1:0], r2[1:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
